// File: rtl/direction_ctrl.sv
// Multi-channel H-bridge direction controller: deadband decode of sign-magnitude
// setpoints plus a forced brake dead-time on every exit from a driving direction.
module direction_ctrl #(
  parameter int unsigned N_CHANNELS  = 4,
  parameter int unsigned N_DATAWIDTH = 17,
  parameter int unsigned N_DEADBAND  = 255,
  parameter int unsigned N_DEADTIME  = 50000,
  parameter int unsigned N_CNTWIDTH  = 16
) (
  input  logic                              DIRECTION_CTRL_CLOCK_50,
  input  logic                              DIRECTION_CTRL_RESET_InLow,
  input  logic                              DIRECTION_CTRL_ENABLE_InHigh,
  input  logic [N_CHANNELS*N_DATAWIDTH-1:0] DIRECTION_CTRL_W_InBus,
  output logic [2*N_CHANNELS-1:0]           DIRECTION_CTRL_CONTROL_OutBus,
  output logic [N_CHANNELS-1:0]             DIRECTION_CTRL_BUSY_OutBus
);

  typedef enum logic [1:0] {S_STOP, S_FWD, S_REV, S_DEAD} state_t;
  typedef enum logic [1:0] {REQ_ZERO, REQ_FWD, REQ_REV} req_t;

  localparam logic [N_DATAWIDTH-2:0] DEADBAND  = (N_DATAWIDTH-1)'(N_DEADBAND);
  localparam logic [N_CNTWIDTH-1:0]  CNT_LOAD  = N_CNTWIDTH'(N_DEADTIME - 1);
  localparam logic [1:0]             CODE_FWD  = 2'b01;
  localparam logic [1:0]             CODE_REV  = 2'b10;
  localparam logic [1:0]             CODE_STOP = 2'b11;

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    logic [N_DATAWIDTH-1:0] w;
    logic [N_DATAWIDTH-2:0] mag;
    logic                   sign;
    req_t                   req;
    state_t                 state;
    logic [N_CNTWIDTH-1:0]  cnt;
    logic [1:0]             control;
    logic                   busy;

    assign w    = DIRECTION_CTRL_W_InBus[i*N_DATAWIDTH +: N_DATAWIDTH];
    assign mag  = w[N_DATAWIDTH-2:0];
    assign sign = w[N_DATAWIDTH-1];

    // Negative zero falls into the deadband because only the magnitude is compared.
    always_comb begin
      req = REQ_ZERO;
      if (mag > DEADBAND) begin
        req = sign ? REQ_REV : REQ_FWD;
      end
    end

    // Outputs are registered alongside the state so they always match its Moore decode.
    always_ff @(posedge DIRECTION_CTRL_CLOCK_50 or negedge DIRECTION_CTRL_RESET_InLow) begin
      if (!DIRECTION_CTRL_RESET_InLow) begin
        state   <= S_STOP;
        cnt     <= '0;
        control <= CODE_STOP;
        busy    <= 1'b0;
      end else if (!DIRECTION_CTRL_ENABLE_InHigh) begin
        state   <= S_DEAD;
        cnt     <= CNT_LOAD;
        control <= CODE_STOP;
        busy    <= 1'b1;
      end else begin
        case (state)
          S_STOP: begin
            case (req)
              REQ_FWD: begin
                state   <= S_FWD;
                control <= CODE_FWD;
              end
              REQ_REV: begin
                state   <= S_REV;
                control <= CODE_REV;
              end
              default: ;
            endcase
          end
          S_FWD: begin
            if (req != REQ_FWD) begin
              state   <= S_DEAD;
              cnt     <= CNT_LOAD;
              control <= CODE_STOP;
              busy    <= 1'b1;
            end
          end
          S_REV: begin
            if (req != REQ_REV) begin
              state   <= S_DEAD;
              cnt     <= CNT_LOAD;
              control <= CODE_STOP;
              busy    <= 1'b1;
            end
          end
          S_DEAD: begin
            if (cnt != '0) begin
              cnt <= cnt - N_CNTWIDTH'(1);
            end else begin
              busy <= 1'b0;
              case (req)
                REQ_FWD: begin
                  state   <= S_FWD;
                  control <= CODE_FWD;
                end
                REQ_REV: begin
                  state   <= S_REV;
                  control <= CODE_REV;
                end
                default: begin
                  state   <= S_STOP;
                  control <= CODE_STOP;
                end
              endcase
            end
          end
          default: begin
            state   <= S_STOP;
            cnt     <= '0;
            control <= CODE_STOP;
            busy    <= 1'b0;
          end
        endcase
      end
    end

    assign DIRECTION_CTRL_CONTROL_OutBus[2*i +: 2] = control;
    assign DIRECTION_CTRL_BUSY_OutBus[i]           = busy;
  end

endmodule

// File: tb/tb_direction_ctrl.sv
// Directed-vector bench for direction_ctrl with two channels and a 4-cycle dead-time.
module tb_direction_ctrl;

  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 17;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic [NCH*DW-1:0]   w;
  logic [2*NCH-1:0]    control;
  logic [NCH-1:0]      busy;

  int unsigned n_vec;
  int unsigned n_err;

  direction_ctrl #(
    .N_CHANNELS (NCH),
    .N_DEADTIME (4)
  ) dut (
    .DIRECTION_CTRL_CLOCK_50       (clk),
    .DIRECTION_CTRL_RESET_InLow    (rst_n),
    .DIRECTION_CTRL_ENABLE_InHigh  (en),
    .DIRECTION_CTRL_W_InBus        (w),
    .DIRECTION_CTRL_CONTROL_OutBus (control),
    .DIRECTION_CTRL_BUSY_OutBus    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [DW-1:0] ch0, input logic [DW-1:0] ch1);
    w = {ch1, ch0};
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    set_w(17'h00300, 17'h00000);

    // Reset state
    step(2);
    check("rst_ctrl", 32'(control), 32'h0000000F);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    step(1);
    check("first_fwd", 32'(control), 32'b1101);
    check("first_busy", 32'(busy), 32'h0);

    // Deadband: 0x000FF is zero, so leave FWD through dead-time back to STOP
    set_w(17'h000FF, 17'h00000);
    step(1);
    check("db_dead_ctrl", 32'(control), 32'b1111);
    check("db_dead_busy", 32'(busy), 32'b01);
    step(4);
    check("db_stop_ctrl", 32'(control), 32'b1111);
    check("db_stop_busy", 32'(busy), 32'b00);
    step(1);
    check("db_hold", 32'(control), 32'b1111);
    set_w(17'h00100, 17'h00000);
    step(1);
    check("db_edge_fwd", 32'(control), 32'b1101);
    set_w(17'h10000, 17'h00000);
    step(5);
    check("negzero_ctrl", 32'(control), 32'b1111);
    check("negzero_busy", 32'(busy), 32'b00);
    step(2);
    check("negzero_hold", 32'(control), 32'b1111);

    // Reversal with ch1 held in reverse
    set_w(17'h00300, 17'h10200);
    step(1);
    check("rev_pre", 32'(control), 32'b1001);
    set_w(17'h10300, 17'h10200);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("rev_dead_ctrl", 32'(control), 32'b1011);
      check("rev_dead_busy", 32'(busy), 32'b01);
    end
    step(1);
    check("rev_done_ctrl", 32'(control), 32'b1010);
    check("rev_done_busy", 32'(busy), 32'b00);

    // Back to forward via STOP, then request change mid dead-time
    set_w(17'h00000, 17'h10200);
    step(5);
    check("to_stop", 32'(control), 32'b1011);
    set_w(17'h00300, 17'h10200);
    step(1);
    check("fwd_again", 32'(control), 32'b1001);
    set_w(17'h00000, 17'h10200);
    step(2);
    check("mid_dead2", 32'(control), 32'b1011);
    set_w(17'h00500, 17'h10200);
    step(1);
    check("mid_dead3", 32'(control), 32'b1011);
    step(1);
    check("mid_dead4_ctrl", 32'(control), 32'b1011);
    check("mid_dead4_busy", 32'(busy), 32'b01);
    step(1);
    check("mid_done", 32'(control), 32'b1001);
    check("mid_done_busy", 32'(busy), 32'b00);

    // Disable for 10 cycles
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("dis_ctrl", 32'(control), 32'b1111);
      check("dis_busy", 32'(busy), 32'b11);
    end
    en = 1'b1;
    check("reen0", 32'(control), 32'b1111);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("reen_ctrl", 32'(control), 32'b1111);
      check("reen_busy", 32'(busy), 32'b11);
    end
    step(1);
    check("reen_done_ctrl", 32'(control), 32'b1001);
    check("reen_done_busy", 32'(busy), 32'b00);

    // Asynchronous reset in the middle of dead-time
    set_w(17'h00000, 17'h10200);
    step(2);
    check("pre_rst_busy", 32'(busy), 32'b01);
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", 32'(control), 32'b1111);
    check("async_rst_busy", 32'(busy), 32'b00);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("post_rst", 32'(control), 32'b1011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
